// File: rtl/scfifo_showahead_reader.sv
// Show-ahead FIFO read side to valid/ready stream adapter.
// A two-entry buffer (output register + skid register) keeps fifo_rdreq free of any out_ready path.
module scfifo_showahead_reader #(
  parameter int WIDTH     = 20,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 aclr,
  input  logic                 sclr,
  input  logic [WIDTH-1:0]     fifo_q,
  input  logic                 fifo_empty,
  output logic                 fifo_rdreq,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] xfer_count,
  output logic [CNT_WIDTH-1:0] stall_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t           state;
  logic [WIDTH-1:0] skid;
  logic             pop;
  logic             take;

  // Popping depends only on registered state, so the skid always has room for a popped word.
  assign fifo_rdreq = ~fifo_empty & (state != TWO);
  assign pop        = fifo_rdreq;
  assign take       = out_valid & out_ready;

  // NOTE: every register here uses <= so all of them sample pre-edge values of each other;
  // the data registers are reset too, since a dropped word must never reappear on out_data.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state       <= EMPTY;
      out_valid   <= 1'b0;
      out_data    <= '0;
      skid        <= '0;
      xfer_count  <= '0;
      stall_count <= '0;
    end else if (sclr) begin
      state       <= EMPTY;
      out_valid   <= 1'b0;
      out_data    <= '0;
      skid        <= '0;
      xfer_count  <= '0;
      stall_count <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (pop) begin
            state     <= ONE;
            out_valid <= 1'b1;
            out_data  <= fifo_q;
          end
        end
        ONE: begin
          if (pop && take) begin
            out_data <= fifo_q;
          end else if (pop) begin
            state <= TWO;
            skid  <= fifo_q;
          end else if (take) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        TWO: begin
          if (take) begin
            state    <= ONE;
            out_data <= skid;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase

      if (take) xfer_count <= xfer_count + CNT_WIDTH'(1);
      if (out_valid && !out_ready && stall_count != CNT_MAX)
        stall_count <= stall_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_scfifo_showahead_reader.sv
// Scoreboard bench: a queue-based FIFO feeds the DUT, a monitor tracks words in flight and the counters.
module tb_scfifo_showahead_reader;
  localparam int WIDTH = 20;
  localparam int CW    = 8;
  localparam int CMAX  = (1 << CW) - 1;

  logic             clock = 1'b0;
  logic             aclr, sclr;
  logic [WIDTH-1:0] fifo_q;
  logic             fifo_empty;
  logic             fifo_rdreq;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    xfer_count, stall_count;

  scfifo_showahead_reader #(.WIDTH(WIDTH), .CNT_WIDTH(CW)) dut (
    .clock(clock), .aclr(aclr), .sclr(sclr),
    .fifo_q(fifo_q), .fifo_empty(fifo_empty), .fifo_rdreq(fifo_rdreq),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .xfer_count(xfer_count), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  logic [WIDTH-1:0] fifo_mem[$];   // upstream show-ahead FIFO contents
  logic [WIDTH-1:0] inflight[$];   // words popped but not yet accepted downstream
  logic             pop_pending = 1'b0;
  int               m_xfer = 0;
  int               m_stall = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    fifo_empty = (fifo_mem.size() == 0);
    fifo_q     = fifo_empty ? '0 : fifo_mem[0];
  endtask

  task automatic push(input logic [WIDTH-1:0] w);
    fifo_mem.push_back(w);
    refresh();
  endtask

  // Advance one cycle; the FIFO pops whatever the DUT requested at that edge.
  task automatic step();
    @(posedge clock);
    #1;
    if (pop_pending && fifo_mem.size() > 0) void'(fifo_mem.pop_front());
    refresh();
  endtask

  // Monitor: mid-cycle sample, compare against the in-flight model, then advance the model.
  always @(negedge clock) begin
    logic take;
    pop_pending = fifo_rdreq;
    if (aclr) begin
      inflight.delete();
      m_xfer  = 0;
      m_stall = 0;
    end else begin
      check("xfer_count", 64'(xfer_count), 64'(m_xfer));
      check("stall_count", 64'(stall_count), 64'(m_stall));
      check("out_valid", 64'(out_valid), 64'(inflight.size() != 0));
      check("fifo_rdreq", 64'(fifo_rdreq), 64'(!fifo_empty && inflight.size() < 2));
      if (out_valid && inflight.size() > 0) check("out_data", 64'(out_data), 64'(inflight[0]));
      take = out_valid && out_ready;
      if (sclr) begin
        inflight.delete();
        m_xfer  = 0;
        m_stall = 0;
      end else begin
        if (take && inflight.size() > 0) void'(inflight.pop_front());
        if (fifo_rdreq && !fifo_empty) inflight.push_back(fifo_q);
        if (take) m_xfer = (m_xfer + 1) % (CMAX + 1);
        if (out_valid && !out_ready && m_stall < CMAX) m_stall++;
      end
    end
  end

  initial begin
    aclr = 1'b1; sclr = 1'b0; out_ready = 1'b0;
    refresh();
    @(negedge clock);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_xfer", 64'(xfer_count), 64'd0);
    check("rst_stall", 64'(stall_count), 64'd0);
    step();
    aclr = 1'b0;

    // First word: pop in the first cycle, presented in the next one.
    push(20'h00001);
    out_ready = 1'b1;
    @(negedge clock);
    check("first_rdreq", 64'(fifo_rdreq), 64'd1);
    step();
    check("first_valid", 64'(out_valid), 64'd1);
    check("first_data", 64'(out_data), 64'h1);
    step();

    // Back-to-back stream 1..8 at full rate.
    sclr = 1'b1;
    step();
    sclr = 1'b0;
    push(20'h1);
    for (int i = 1; i <= 8; i++) begin
      step();
      check("stream_valid", 64'(out_valid), 64'd1);
      check("stream_data", 64'(out_data), 64'(i));
      if (i < 8) push(WIDTH'(i + 1));
    end
    step();
    check("stream_xfer", 64'(xfer_count), 64'd8);
    check("stream_stall", 64'(stall_count), 64'd0);

    // Backpressure fills both registers; third word stays in the FIFO.
    out_ready = 1'b0;
    push(20'h1); push(20'h2); push(20'h3);
    repeat (4) step();
    check("two_data", 64'(out_data), 64'h1);
    check("two_rdreq", 64'(fifo_rdreq), 64'd0);
    check("two_fifo_left", 64'(fifo_mem.size()), 64'd1);
    check("two_stall", 64'(stall_count), 64'd3);
    out_ready = 1'b1;
    for (int i = 2; i <= 3; i++) begin
      step();
      check("drain_valid", 64'(out_valid), 64'd1);
      check("drain_data", 64'(out_data), 64'(i));
    end
    step();
    check("drain_empty", 64'(out_valid), 64'd0);

    // Synchronous clear while full with a take pending.
    out_ready = 1'b0;
    push(20'hA); push(20'hB); push(20'hC);
    repeat (3) step();
    out_ready = 1'b1;
    sclr = 1'b1;
    step();
    sclr = 1'b0;
    check("sclr_valid", 64'(out_valid), 64'd0);
    check("sclr_xfer", 64'(xfer_count), 64'd0);
    check("sclr_stall", 64'(stall_count), 64'd0);
    out_ready = 1'b0;

    // Stall counter saturation.
    repeat (CMAX + 7) step();
    check("stall_sat", 64'(stall_count), 64'(CMAX));

    // Transfer counter wrap.
    sclr = 1'b1;
    step();
    sclr = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < CMAX; i++) begin
      push(WIDTH'($urandom));
      step();
    end
    step();
    check("xfer_max", 64'(xfer_count), 64'(CMAX));
    push(20'h5A5A5);
    repeat (3) step();
    check("xfer_wrap", 64'(xfer_count), 64'd0);

    // Randomised traffic, backpressure and occasional clears.
    for (int c = 0; c < 2000; c++) begin
      if (fifo_mem.size() < 6 && $urandom_range(0, 2) != 0) push(WIDTH'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      sclr = ($urandom_range(0, 149) == 0);
      step();
    end
    sclr = 1'b0;
    out_ready = 1'b1;
    repeat (20) step();
    check("final_drained", 64'(inflight.size() + fifo_mem.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
